// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file.
// Selects the write-back value, commits it, and serves two bypassed read ports.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    RegWrite_in,
    input  logic                    MemtoReg_in,
    input  logic [DATA_W-1:0]       D_MEM_read_data_in,
    input  logic [DATA_W-1:0]       D_MEM_read_addr_in,
    input  logic [$clog2(NREG)-1:0] MEM_WB_RegisterRd_in,
    input  logic [$clog2(NREG)-1:0] ID_rs_addr,
    input  logic [$clog2(NREG)-1:0] ID_rt_addr,
    output logic [DATA_W-1:0]       ID_rs_data,
    output logic [DATA_W-1:0]       ID_rt_data,
    output logic [DATA_W-1:0]       WB_data_out,
    output logic                    WB_write_en_out
);

    localparam int unsigned IDX_W = $clog2(NREG);

    logic [NREG-1:0][DATA_W-1:0] regFile;
    logic                        rdNonZero;
    logic                        rsHit;
    logic                        rtHit;

    // Write-back select and effective write strobe (index 0 never writes).
    always_comb begin
        WB_data_out     = MemtoReg_in ? D_MEM_read_data_in : D_MEM_read_addr_in;
        rdNonZero       = (MEM_WB_RegisterRd_in != IDX_W'(0));
        WB_write_en_out = RegWrite_in & rdNonZero & ~rst;
    end

    // Storage: reset clears every entry and overrides any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            regFile <= '0;
        end else if (WB_write_en_out) begin
            regFile[MEM_WB_RegisterRd_in] <= WB_data_out;
        end
    end

    // Read ports with write-through bypass; the strobe already excludes reset.
    always_comb begin
        rsHit = WB_write_en_out && (MEM_WB_RegisterRd_in == ID_rs_addr);
        rtHit = WB_write_en_out && (MEM_WB_RegisterRd_in == ID_rt_addr);

        if (ID_rs_addr == IDX_W'(0)) begin
            ID_rs_data = '0;
        end else if (rsHit) begin
            ID_rs_data = WB_data_out;
        end else begin
            ID_rs_data = regFile[ID_rs_addr];
        end

        if (ID_rt_addr == IDX_W'(0)) begin
            ID_rt_data = '0;
        end else if (rtHit) begin
            ID_rt_data = WB_data_out;
        end else begin
            ID_rt_data = regFile[ID_rt_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table followed by a randomized soak
// against an array-based register model.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        RegWrite_in;
    logic        MemtoReg_in;
    logic [31:0] D_MEM_read_data_in;
    logic [31:0] D_MEM_read_addr_in;
    logic [4:0]  MEM_WB_RegisterRd_in;
    logic [4:0]  ID_rs_addr;
    logic [4:0]  ID_rt_addr;
    logic [31:0] ID_rs_data;
    logic [31:0] ID_rt_data;
    logic [31:0] WB_data_out;
    logic        WB_write_en_out;

    int testsRun;
    int testsFailed;

    logic [31:0] model [32];

    wb_regfile dut (
        .clk                  (clk),
        .rst                  (rst),
        .RegWrite_in          (RegWrite_in),
        .MemtoReg_in          (MemtoReg_in),
        .D_MEM_read_data_in   (D_MEM_read_data_in),
        .D_MEM_read_addr_in   (D_MEM_read_addr_in),
        .MEM_WB_RegisterRd_in (MEM_WB_RegisterRd_in),
        .ID_rs_addr           (ID_rs_addr),
        .ID_rt_addr           (ID_rt_addr),
        .ID_rs_data           (ID_rs_data),
        .ID_rt_data           (ID_rt_data),
        .WB_data_out          (WB_data_out),
        .WB_write_en_out      (WB_write_en_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rw;
        logic        m2r;
        logic [31:0] data;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] expRs;
        logic [31:0] expRt;
        logic [31:0] expWb;
        logic        expWen;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic r, logic w, logic m, logic [31:0] d, logic [31:0] a,
                                logic [4:0] rdI, logic [4:0] rsI, logic [4:0] rtI,
                                logic [31:0] ers, logic [31:0] ert, logic [31:0] ewb,
                                logic ewen);
        vec_t v;
        v.rst = r; v.rw = w; v.m2r = m; v.data = d; v.addr = a;
        v.rd = rdI; v.rs = rsI; v.rt = rtI;
        v.expRs = ers; v.expRt = ert; v.expWb = ewb; v.expWen = ewen;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic w, logic m, logic [31:0] d, logic [31:0] a,
                         logic [4:0] rdI, logic [4:0] rsI, logic [4:0] rtI);
        rst                  = r;
        RegWrite_in          = w;
        MemtoReg_in          = m;
        D_MEM_read_data_in   = d;
        D_MEM_read_addr_in   = a;
        MEM_WB_RegisterRd_in = rdI;
        ID_rs_addr           = rsI;
        ID_rt_addr           = rtI;
    endtask

    // Architectural effect of one clock edge on the model, from the current inputs.
    task automatic clockEdge();
        logic [31:0] wb;
        @(posedge clk);
        wb = MemtoReg_in ? D_MEM_read_data_in : D_MEM_read_addr_in;
        if (rst) begin
            foreach (model[i]) model[i] = 32'h0;
        end else if (RegWrite_in && MEM_WB_RegisterRd_in != 5'd0) begin
            model[MEM_WB_RegisterRd_in] = wb;
        end
        #1;
    endtask

    function automatic logic [31:0] modelRead(logic [4:0] idx, logic wen, logic [4:0] rdI,
                                              logic [31:0] wb);
        if (idx == 5'd0) return 32'h0;
        if (wen && rdI == idx) return wb;
        return model[idx];
    endfunction

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        foreach (model[i]) model[i] = 32'h0;

        //            rst rw m2r data          addr          rd  rs  rt  expRs         expRt         expWb         wen
        vecs[0]  = mk(0, 1, 0, 32'h0,        32'hDEADBEEF, 5,  5,  0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1);
        vecs[1]  = mk(0, 0, 0, 32'h0,        32'h0,        0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0);
        vecs[2]  = mk(1, 0, 0, 32'h0,        32'h0,        0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0);
        vecs[3]  = mk(0, 0, 0, 32'h0,        32'h0,        0,  5,  5,  32'h0,        32'h0,        32'h0,        0);
        vecs[4]  = mk(0, 1, 1, 32'h12345678, 32'h0000ABCD, 8,  8,  0,  32'h12345678, 32'h0,        32'h12345678, 1);
        vecs[5]  = mk(0, 1, 0, 32'h12345678, 32'h0000ABCD, 9,  8,  9,  32'h12345678, 32'h0000ABCD, 32'h0000ABCD, 1);
        vecs[6]  = mk(0, 0, 0, 32'h12345678, 32'h0000ABCD, 9,  8,  9,  32'h12345678, 32'h0000ABCD, 32'h0000ABCD, 0);
        vecs[7]  = mk(0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  0,  0,  32'h0,        32'h0,        32'hFFFFFFFF, 0);
        vecs[8]  = mk(0, 0, 0, 32'h0,        32'h0,        0,  0,  0,  32'h0,        32'h0,        32'h0,        0);
        vecs[9]  = mk(0, 1, 0, 32'h0,        32'h11111111, 3,  0,  0,  32'h0,        32'h0,        32'h11111111, 1);
        vecs[10] = mk(0, 1, 0, 32'h0,        32'h22222222, 3,  3,  3,  32'h22222222, 32'h22222222, 32'h22222222, 1);
        vecs[11] = mk(0, 0, 0, 32'h0,        32'h0,        0,  3,  3,  32'h22222222, 32'h22222222, 32'h0,        0);
        vecs[12] = mk(0, 0, 0, 32'h0,        32'hCAFEF00D, 7,  7,  7,  32'h0,        32'h0,        32'hCAFEF00D, 0);
        vecs[13] = mk(0, 0, 0, 32'h0,        32'h0,        0,  7,  3,  32'h0,        32'h22222222, 32'h0,        0);
        vecs[14] = mk(1, 1, 0, 32'h0,        32'hCAFEF00D, 7,  7,  3,  32'h0,        32'h22222222, 32'hCAFEF00D, 0);
        vecs[15] = mk(0, 0, 0, 32'h0,        32'h0,        0,  7,  3,  32'h0,        32'h0,        32'h0,        0);
        vecs[16] = mk(0, 1, 1, 32'hAAAA0001, 32'h0,        10, 10, 0,  32'hAAAA0001, 32'h0,        32'hAAAA0001, 1);
        vecs[17] = mk(0, 1, 1, 32'hAAAA0002, 32'h0,        10, 10, 10, 32'hAAAA0002, 32'hAAAA0002, 32'hAAAA0002, 1);
        vecs[18] = mk(0, 0, 1, 32'h0,        32'h0,        10, 10, 0,  32'hAAAA0002, 32'h0,        32'h0,        0);

        // Initial reset: contents are undefined until the first reset edge.
        drive(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        #2;
        check("reset wen", 32'(WB_write_en_out), 32'h0);
        clockEdge();
        clockEdge();

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].rw, vecs[i].m2r, vecs[i].data, vecs[i].addr,
                  vecs[i].rd, vecs[i].rs, vecs[i].rt);
            #2;
            check($sformatf("vec%0d rs", i),  ID_rs_data,  vecs[i].expRs);
            check($sformatf("vec%0d rt", i),  ID_rt_data,  vecs[i].expRt);
            check($sformatf("vec%0d wb", i),  WB_data_out, vecs[i].expWb);
            check($sformatf("vec%0d wen", i), 32'(WB_write_en_out), 32'(vecs[i].expWen));
            clockEdge();
        end

        // Randomized soak with occasional resets and address collisions.
        for (int c = 0; c < 2000; c++) begin
            logic        r, w, m, wen;
            logic [31:0] d, a, wb;
            logic [4:0]  rdI, rsI, rtI;
            r   = ($urandom_range(0, 99) < 3);
            w   = ($urandom_range(0, 99) < 70);
            m   = 1'($urandom);
            d   = $urandom;
            a   = $urandom;
            rdI = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            rsI = ($urandom_range(0, 3) == 0) ? rdI : 5'($urandom);
            rtI = ($urandom_range(0, 3) == 0) ? rdI : 5'($urandom);
            drive(r, w, m, d, a, rdI, rsI, rtI);
            wb  = m ? d : a;
            wen = w && (rdI != 5'd0) && !r;
            #2;
            check($sformatf("soak%0d rs", c),  ID_rs_data,  modelRead(rsI, wen, rdI, wb));
            check($sformatf("soak%0d rt", c),  ID_rt_data,  modelRead(rtI, wen, rdI, wb));
            check($sformatf("soak%0d wb", c),  WB_data_out, wb);
            check($sformatf("soak%0d wen", c), 32'(WB_write_en_out), 32'(wen));
            clockEdge();
        end

        // Full sweep of stored contents against the model.
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 32'h0, 32'h0, 0, 5'(i), 5'(31 - i));
            #2;
            check($sformatf("sweep r%0d", i),      ID_rs_data, model[i]);
            check($sformatf("sweep r%0d", 31 - i), ID_rt_data, model[31 - i]);
            clockEdge();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file. It consumes the registered outputs of the MEM/WB pipeline register.
- Selects the write-back value (memory load data or ALU result) under MemtoReg and commits it to a 32 x 32-bit register file.
- Serves the two ID-stage read ports (rs, rt), with write-through bypass so a same-cycle write is visible to readers.
- Closes the MEM/WB interface from the receiving end.

Parameters:
- DATA_W, 32, register and data width.
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- RegWrite_in  input  1  write enable from MEM/WB.
- MemtoReg_in  input  1  1 = write memory read data; 0 = write ALU result.
- D_MEM_read_data_in  input  32  load data from MEM/WB.
- D_MEM_read_addr_in  input  32  ALU result / memory address from MEM/WB.
- MEM_WB_RegisterRd_in  input  5  destination register index.
- ID_rs_addr  input  5  read port A index.
- ID_rt_addr  input  5  read port B index.
- ID_rs_data  output  32  read port A data, combinational.
- ID_rt_data  output  32  read port B data, combinational.
- WB_data_out  output  32  selected write-back value, combinational; feeds the forwarding unit.
- WB_write_en_out  output  1  effective write strobe: RegWrite_in & (rd != 0) & ~rst.

Behaviour:
- Write-back select:
  - WB_data_out = MemtoReg_in ? D_MEM_read_data_in : D_MEM_read_addr_in.
  - Pure mux: no truncation and no sign handling.
- Commit:
  - On a rising edge with rst=0, RegWrite_in=1 and MEM_WB_RegisterRd_in != 0, reg[rd] <= WB_data_out.
  - Latency: the value is architecturally stored 1 cycle after presentation, and visible to readers in the same cycle through the bypass.
- Register 0:
  - Hardwired zero. Writes to index 0 are discarded, with no storage update and no bypass.
  - WB_write_en_out stays 0 for such writes.
- Reads:
  - ID_rs_data = (rs == 0) ? 0 : (WB_write_en_out && rd == rs) ? WB_data_out : reg[rs]. ID_rt_data follows the same rule with rt.
  - Both ports are independent. rs == rt returns identical data on both ports.
- Simultaneous events:
  - A read and a write to the same index in the same cycle return the new value through the bypass.
  - Two consecutive writes to the same index: the last write wins.
  - RegWrite_in=0 leaves the storage unchanged whatever MemtoReg_in and the data inputs carry.
- Reset:
  - While rst=1, WB_write_en_out=0 and no commit occurs.
  - On a rising edge with rst=1, all NREG registers are cleared to 0.
  - While rst=1 the read ports return the current stored contents with the bypass disabled. After the first reset edge the stored contents are all zero.
  - Reset asserted mid-stream, in the same cycle as a valid write: the reset takes priority, the write is lost and the register reads 0 afterwards.
  - WB_data_out is unaffected by rst because it is combinational from its inputs.
- Unknown inputs:
  - An X on RegWrite_in may corrupt storage.
  - The block does not guard against X; upstream MEM/WB reset guarantees RegWrite_in=0 after reset.
- No internal state other than the register array; no state machine.

Test Plan:
- Reset clear:
  - Write 0xDEADBEEF to r5, then assert rst for 1 cycle.
  - Required: rs=5 reads 0x00000000, and WB_write_en_out=0 during reset.
- Mux and commit:
  - Cycle 1: RegWrite=1, MemtoReg=1, data=0x12345678, addr=0x0000ABCD, rd=8.
  - Cycle 2: RegWrite=1, MemtoReg=0, same data inputs, rd=9.
  - Required: r8=0x12345678 and r9=0x0000ABCD. WB_data_out matches each cycle combinationally.
- Zero register:
  - RegWrite=1, rd=0, data=0xFFFFFFFF.
  - Required: WB_write_en_out=0; rs=0 and rt=0 read 0x00000000 in the same cycle and all later cycles.
- Bypass:
  - r3 holds 0x11111111. In one cycle: RegWrite=1, MemtoReg=0, addr=0x22222222, rd=3, rs=3, rt=3.
  - Required: both ports read 0x22222222 in that cycle, and r3=0x22222222 after the edge.
- Write disabled and reset priority:
  - RegWrite=0, rd=7, addr=0xCAFEF00D. Required: r7 unchanged (0).
  - Then rst=1 together with RegWrite=1, rd=7. Required: r7 stays 0.
- Randomized soak:
  - 2000 cycles of $random stimulus with a reference model of 32 registers.
  - Required: both read ports match the model every cycle, and no mismatch occurs across randomly inserted resets.
